// File: rtl/dsp_pkg.sv
// Shared state encoding and dsp interface widths for the dsp job sequencer.
package dsp_pkg;

  localparam int DSP_PARAM_W = 8;
  localparam int DSP_ADDR_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_KICK  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_READ  = 3'd4,
    ST_DRAIN = 3'd5
  } state_t;

endpackage

// File: rtl/dsp_seq_skid.sv
// Two-entry valid/ready buffer holding readback words; entry 0 is always the head.
module dsp_seq_skid #(
  parameter int WIDTH = 25
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_e0;
  logic [WIDTH-1:0] r_e1;
  logic [1:0]       r_count;
  logic             w_pop;

  assign w_pop   = (r_count != 2'd0) && i_ready;
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_e0;
  assign o_count = r_count;

  // Head only moves on a pop or a push into an empty buffer, so stalled data stays put.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_e0    <= '0;
      r_e1    <= '0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else begin
      case ({i_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_e0 <= i_data;
          else                 r_e1 <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_e0    <= r_e1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_e0 <= i_data;
          end else begin
            r_e0 <= r_e1;
            r_e1 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dsp_seq_ctrl.sv
// Job sequencer: loads samples into the dsp, kicks it, then streams every slot back out.
module dsp_seq_ctrl
  import dsp_pkg::*;
#(
  parameter int BUS_WIDTH = 24,
  parameter int SLOTS     = 8,
  parameter int CNT_W     = 8,
  parameter int WAIT_CYC  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [CNT_W-1:0]       i_cmd_len,
  input  logic [DSP_ADDR_W-1:0]  i_cmd_mode,
  input  logic                   i_abort,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [BUS_WIDTH-1:0]   i_in_data,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [BUS_WIDTH-1:0]   o_out_data,
  output logic                   o_out_last,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic                   o_dsp_en,
  output logic                   o_dsp_start,
  output logic [DSP_PARAM_W-1:0] o_dsp_param,
  output logic [DSP_ADDR_W-1:0]  o_dsp_addr,
  output logic [BUS_WIDTH-1:0]   o_dsp_din,
  output logic                   o_dsp_we,
  input  logic [BUS_WIDTH-1:0]   i_dsp_dout
);

  state_t r_state;
  state_t w_state_next;

  logic [CNT_W-1:0]       r_len;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_slot;
  logic [DSP_ADDR_W-1:0]  r_mode;
  logic [DSP_PARAM_W-1:0] r_param;
  logic                   r_inf1;
  logic                   r_inf1_last;
  logic                   r_inf2;
  logic                   r_inf2_last;
  logic                   r_done;
  logic                   r_err;

  logic                   w_abort;
  logic                   w_cmd_fire;
  logic                   w_len_ok;
  logic                   w_in_fire;
  logic                   w_last_word;
  logic                   w_wait_done;
  logic [2:0]             w_credit;
  logic                   w_issue;
  logic                   w_out_fire;
  logic                   w_final;
  logic                   w_skid_valid;
  logic [1:0]             w_skid_count;
  logic [BUS_WIDTH:0]     w_skid_data;

  assign w_abort     = i_abort && (r_state != ST_IDLE);
  assign o_cmd_ready = (r_state == ST_IDLE);
  assign w_cmd_fire  = i_cmd_valid && o_cmd_ready;
  assign w_len_ok    = (i_cmd_len != '0) && (i_cmd_len <= CNT_W'(SLOTS));

  assign o_in_ready  = (r_state == ST_LOAD) && !w_abort;
  assign w_in_fire   = i_in_valid && o_in_ready;
  assign w_last_word = (r_cnt == r_len - 1'b1);
  assign w_wait_done = (r_cnt == CNT_W'(WAIT_CYC - 1));

  // Words already buffered plus reads still in the two-stage dsp pipe must leave room.
  assign w_credit = {1'b0, w_skid_count} + {2'b00, r_inf1} + {2'b00, r_inf2};
  assign w_issue  = (r_state == ST_READ) && !w_abort && (w_credit < 3'd2);

  assign w_out_fire = w_skid_valid && i_out_ready;
  assign w_final    = w_out_fire && w_skid_data[BUS_WIDTH] && (r_state == ST_DRAIN);

  assign o_busy      = (r_state != ST_IDLE);
  assign o_dsp_en    = o_busy;
  assign o_dsp_we    = w_in_fire;
  assign o_dsp_din   = w_in_fire ? i_in_data : '0;
  assign o_dsp_start = (r_state == ST_KICK) && !w_abort;
  assign o_dsp_param = r_param;
  assign o_dsp_addr  = r_mode;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_out_valid = w_skid_valid;
  assign o_out_data  = w_skid_data[BUS_WIDTH-1:0];
  assign o_out_last  = w_skid_valid && w_skid_data[BUS_WIDTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_cmd_fire && w_len_ok) w_state_next = ST_LOAD;
      ST_LOAD:  if (w_in_fire && w_last_word) w_state_next = ST_KICK;
      ST_KICK:  w_state_next = ST_WAIT;
      ST_WAIT:  if (w_wait_done) w_state_next = ST_READ;
      ST_READ:  if (w_issue && (r_slot == '0)) w_state_next = ST_DRAIN;
      ST_DRAIN: if (w_final) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
    if (w_abort) w_state_next = ST_IDLE;
  end

  // Slots are issued from len-1 down to 0 so results come back oldest first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len       <= '0;
      r_cnt       <= '0;
      r_slot      <= '0;
      r_mode      <= '0;
      r_param     <= '0;
      r_inf1      <= 1'b0;
      r_inf1_last <= 1'b0;
      r_inf2      <= 1'b0;
      r_inf2_last <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err       <= w_cmd_fire && !w_len_ok;
      r_done      <= w_final && !w_abort;
      r_inf1      <= w_issue;
      r_inf1_last <= w_issue && (r_slot == '0);
      r_inf2      <= r_inf1 && !w_abort;
      r_inf2_last <= r_inf1_last;
      if (w_abort) begin
        r_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_cmd_fire && w_len_ok) begin
              r_len  <= i_cmd_len;
              r_mode <= i_cmd_mode;
              r_cnt  <= '0;
            end
          end
          ST_LOAD: begin
            if (w_in_fire) r_cnt <= w_last_word ? '0 : r_cnt + 1'b1;
          end
          ST_WAIT: begin
            if (w_wait_done) begin
              r_cnt  <= '0;
              r_slot <= r_len - 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_READ: begin
            if (w_issue) begin
              r_param <= DSP_PARAM_W'(r_slot);
              r_slot  <= r_slot - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  dsp_seq_skid #(
    .WIDTH (BUS_WIDTH + 1)
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (w_abort),
    .i_push  (r_inf2 && !w_abort),
    .i_data  ({r_inf2_last, i_dsp_dout}),
    .i_ready (i_out_ready),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data),
    .o_count (w_skid_count)
  );

endmodule

// File: tb/tb_dsp_seq_ctrl.sv
// Directed and randomized checks of dsp_seq_ctrl against a job-level reference model and dsp model.
module tb_dsp_seq_ctrl;

  localparam int BW    = 24;
  localparam int SLOTS = 8;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_len;
  logic [2:0]    cmd_mode;
  logic          abort;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          err;
  logic          dsp_en;
  logic          dsp_start;
  logic [7:0]    dsp_param;
  logic [2:0]    dsp_addr;
  logic [BW-1:0] dsp_din;
  logic          dsp_we;
  logic [BW-1:0] dsp_dout;

  int errors = 0;
  int checks = 0;

  logic [BW-1:0] samples[$];
  logic [BW-1:0] weLog[$];
  logic [BW:0]   outLog[$];
  logic [7:0]    paramLog[$];
  logic [7:0]    lastParam = 8'd0;
  logic [2:0]    expMode = 3'd0;
  int            readyMode = 0;
  int            cyc = 0;
  int            startCnt, doneCnt, errCnt, busyCnt, addrBad, stallBad, weBad;
  int            lastHsCyc, doneCyc;
  logic          heldValid = 1'b0;
  logic [BW-1:0] heldData;
  logic          heldLast;

  logic [BW-1:0] dspMem [0:SLOTS-1];

  dsp_seq_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_len   (cmd_len),
    .i_cmd_mode  (cmd_mode),
    .i_abort     (abort),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_last  (out_last),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .o_dsp_en    (dsp_en),
    .o_dsp_start (dsp_start),
    .o_dsp_param (dsp_param),
    .o_dsp_addr  (dsp_addr),
    .o_dsp_din   (dsp_din),
    .o_dsp_we    (dsp_we),
    .i_dsp_dout  (dsp_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dsp model: shift register written by we, registered readback of the selected slot.
  initial begin
    for (int i = 0; i < SLOTS; i++) dspMem[i] = '0;
    dsp_dout = '0;
  end
  always @(posedge clk) begin
    if (dsp_we) begin
      for (int i = SLOTS - 1; i > 0; i--) dspMem[i] <= dspMem[i-1];
      dspMem[0] <= dsp_din;
    end
    dsp_dout <= (dsp_param < 8'(SLOTS)) ? dspMem[dsp_param[2:0]] : '0;
  end

  // Result-side ready: 0 always on, 1 random, 2 1-0-0-1 with a 20-cycle stall, else held low.
  initial begin
    int k;
    int prevMode;
    logic [3:0] pattBits;
    pattBits = 4'b1001;
    out_ready = 1'b0;
    k = 0;
    prevMode = -1;
    forever begin
      @(posedge clk);
      #1;
      if (readyMode != prevMode) k = 0;
      prevMode = readyMode;
      case (readyMode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = (k >= 12 && k < 32) ? 1'b0 : pattBits[k % 4];
        default: out_ready = 1'b0;
      endcase
      k++;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (dsp_we) weLog.push_back(dsp_din);
      if (dsp_we && !in_ready) weBad++;
      if (dsp_start) startCnt++;
      if (busy) busyCnt++;
      if (err) errCnt++;
      if (done) begin
        doneCnt++;
        doneCyc = cyc;
      end
      if (out_valid && out_ready) begin
        outLog.push_back({out_last, out_data});
        if (out_last) lastHsCyc = cyc;
      end
      if (busy && dsp_addr !== expMode) addrBad++;
      if (heldValid && (!out_valid || out_data !== heldData || out_last !== heldLast)) stallBad++;
      heldValid = out_valid && !out_ready && !abort;
      heldData  = out_data;
      heldLast  = out_last;
      if (dsp_param !== lastParam) paramLog.push_back(dsp_param);
      lastParam = dsp_param;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetValues();
    checkOutput("rst_flags", {cmd_ready, busy, dsp_en, out_valid, out_last, done, err,
                              dsp_start, dsp_we, in_ready}, 32'h200);
    checkOutput("rst_out_data", 32'(out_data), 32'h0);
    checkOutput("rst_dsp_din", 32'(dsp_din), 32'h0);
    checkOutput("rst_param_addr", {21'h0, dsp_addr, dsp_param}, 32'h0);
  endtask

  task automatic clearLogs();
    weLog.delete();
    outLog.delete();
    paramLog.delete();
    startCnt = 0; doneCnt = 0; errCnt = 0; busyCnt = 0;
    addrBad = 0; stallBad = 0; weBad = 0;
    lastHsCyc = -1; doneCyc = -100;
    heldValid = 1'b0;
  endtask

  task automatic fillRandom(input int len);
    samples.delete();
    for (int i = 0; i < len; i++) samples.push_back(BW'($urandom));
  endtask

  task automatic sendCmd(input int len, input int mode);
    cmd_valid = 1'b1;
    cmd_len   = 8'(len);
    cmd_mode  = 3'(mode);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int count, input bit gaps);
    int idx;
    int n;
    idx = 0;
    n = 0;
    while (idx < count && n < 200) begin
      in_valid = gaps ? ((n % 2) == 0) : 1'b1;
      in_data  = samples[idx];
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    checkOutput("load_accepted", idx, count);
  endtask

  task automatic runJob(input int len, input int mode, input bit gaps);
    logic [7:0] prevParam;
    logic [7:0] expParam[$];
    bit gotDone;
    int n;
    clearLogs();
    expMode = 3'(mode);
    prevParam = lastParam;
    sendCmd(len, mode);
    applyStimulus(len, gaps);
    gotDone = 1'b0;
    n = 0;
    while (!gotDone && n < 3000) begin
      @(negedge clk);
      if (done) gotDone = 1'b1;
      n++;
    end
    @(posedge clk);
    #1;
    checkOutput("done_seen", 32'(gotDone), 32'h1);
    checkOutput("we_count", weLog.size(), len);
    for (int i = 0; i < len; i++)
      checkOutput("we_data", (i < weLog.size()) ? 32'(weLog[i]) : 32'hDEADBEEF, 32'(samples[i]));
    checkOutput("we_outside_load", weBad, 0);
    checkOutput("start_count", startCnt, 1);
    checkOutput("out_count", outLog.size(), len);
    for (int i = 0; i < len; i++)
      checkOutput("out_word", (i < outLog.size()) ? 32'(outLog[i]) : 32'hDEADBEEF,
                  32'({(i == len - 1), samples[i]}));
    for (int s = len - 1; s >= 0; s--)
      if (!(s == len - 1 && 8'(s) == prevParam)) expParam.push_back(8'(s));
    checkOutput("param_count", paramLog.size(), expParam.size());
    for (int i = 0; i < expParam.size(); i++)
      checkOutput("param_seq", (i < paramLog.size()) ? 32'(paramLog[i]) : 32'hDEADBEEF,
                  32'(expParam[i]));
    checkOutput("done_count", doneCnt, 1);
    checkOutput("done_latency", doneCyc - lastHsCyc, 1);
    checkOutput("addr_hold", addrBad, 0);
    checkOutput("stall_hold", stallBad, 0);
    checkOutput("err_quiet", errCnt, 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b1;
    cmd_valid = 1'b0; cmd_len = '0; cmd_mode = '0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0;
    #1 rst_n = 1'b0;
    #1;
    checkResetValues();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] basic job");
    readyMode = 0;
    samples = '{24'h11, 24'h22, 24'h33};
    runJob(3, 5, 1'b0);

    $display("[TB] rejected commands");
    for (int r = 0; r < 2; r++) begin
      clearLogs();
      sendCmd((r == 0) ? 0 : SLOTS + 1, 6);
      @(negedge clk);
      checkOutput("reject_err", {31'h0, err}, 32'h1);
      checkOutput("reject_busy", {31'h0, busy}, 32'h0);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1;
      checkOutput("reject_err_count", errCnt, 1);
      checkOutput("reject_busy_count", busyCnt, 0);
      checkOutput("reject_we", weLog.size(), 0);
      checkOutput("reject_start", startCnt, 0);
    end

    $display("[TB] backpressure");
    readyMode = 2;
    fillRandom(8);
    runJob(8, 3, 1'b0);

    $display("[TB] input gaps");
    readyMode = 0;
    fillRandom(4);
    runJob(4, 2, 1'b1);

    $display("[TB] abort in LOAD");
    clearLogs();
    expMode = 3'd1;
    fillRandom(5);
    sendCmd(5, 1);
    applyStimulus(2, 1'b0);
    abort = 1'b1;
    in_valid = 1'b1;
    in_data = samples[2];
    @(negedge clk);
    checkOutput("abort_load_we", {31'h0, dsp_we}, 32'h0);
    checkOutput("abort_load_in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort_load_idle", {30'h0, busy, cmd_ready}, 32'h1);
    repeat (3) @(negedge clk);
    checkOutput("abort_load_done", doneCnt, 0);
    checkOutput("abort_load_words", weLog.size(), 2);
    checkOutput("abort_load_start", startCnt, 0);
    @(posedge clk);
    #1;

    $display("[TB] abort in READ");
    readyMode = 3;
    clearLogs();
    expMode = 3'd4;
    fillRandom(4);
    sendCmd(4, 4);
    applyStimulus(4, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checkOutput("abort_read_pending", {31'h0, out_valid}, 32'h1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    checkOutput("abort_read_flush", {30'h0, out_valid, busy}, 32'h0);
    checkOutput("abort_read_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    repeat (3) @(negedge clk);
    checkOutput("abort_read_done", doneCnt, 0);
    @(posedge clk);
    #1;
    readyMode = 1;
    fillRandom(6);
    runJob(6, 7, 1'b0);

    $display("[TB] reset mid-READ");
    readyMode = 3;
    clearLogs();
    expMode = 3'd2;
    fillRandom(6);
    sendCmd(6, 2);
    applyStimulus(6, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    checkResetValues();
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    readyMode = 0;
    fillRandom(1);
    runJob(1, 6, 1'b0);

    $display("[TB] random jobs");
    for (int j = 0; j < 4; j++) begin
      int len;
      len = $urandom_range(1, SLOTS);
      fillRandom(len);
      readyMode = 1;
      runJob(len, $urandom_range(0, 7), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
